sdram_port_arbiter: RTL and testbench

- Shares the single SRAM-like port of sdram_ddr_wrapper between two requesters.
- Port 0 is the CPU (fast memory, priority). Port 1 is chipset/DMA.
- Owns the wrapper CS/ready handshake, so requesters see a simple req/ack protocol.
- Guarantees port 1 forward progress with a starvation limit.
- Sits between the Minimig core and sdram_ddr_wrapper, clocked by the wrapper's o_ui_clk.

---
 rtl/sdram_arb_pkg.sv | 11 +
 rtl/sdram_arb_grant.sv | 25 ++
 rtl/sdram_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, port indices and counter widths for the SDRAM port arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_CHIP = 1'b1;
  localparam int   STARVE_W  = 4;
endpackage

// File: rtl/sdram_arb_grant.sv
// sdram_arb_grant: CPU-priority port select with a saturating starvation counter for the chipset port.
module sdram_arb_grant
  import sdram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic p0_req_i,
  input  logic p1_req_i,
  input  logic take_i,
  output logic sel_o
);
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  always_comb begin
    sel_o = (p1_req_i && (!p0_req_i || cnt_q >= STARVE_W'(MAX_WAIT))) ? PORT_CHIP : PORT_CPU;
    cnt_d = !take_i                      ? cnt_q :
            sel_o == PORT_CHIP           ? '0 :
            (p1_req_i && cnt_q != '1)    ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the sdram_ddr_wrapper SRAM-like port between CPU (port 0) and chipset (port 1)
// behind a req/ack handshake, with starvation limit and sticky transaction timeout.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p0_we,
  input  logic              p1_we,
  input  logic              p0_l,
  input  logic              p1_l,
  input  logic              p0_u,
  input  logic              p1_u,
  input  logic [15:0]       p0_wdata,
  input  logic [15:0]       p1_wdata,
  input  logic              p0_big,
  input  logic              p1_big,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [15:0]       p0_rdata,
  output logic [15:0]       p1_rdata,
  output logic [47:0]       p0_rdata48,
  output logic [47:0]       p1_rdata48,
  output logic [ADDR_W-1:0] m_Addr,
  output logic              m_CS,
  output logic              m_L,
  output logic              m_U,
  output logic              m_WE,
  output logic [15:0]       m_WR,
  output logic              m_big_r,
  input  logic [15:0]       m_RD,
  input  logic [47:0]       m_RD48,
  input  logic              m_ready,
  output logic              o_grant,
  output logic              o_busy,
  output logic              o_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d, l_q, l_d, u_q, u_d, we_q, we_d, big_q, big_d;
  logic                txw_q, txw_d, grant_q, grant_d, busy_q, busy_d, to_q, to_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic [15:0]         wr_q, wr_d, rd0_q, rd0_d, rd1_q, rd1_d;
  logic [47:0]         rd48_0_q, rd48_0_d, rd48_1_q, rd48_1_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                sel, take;
  sdram_arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
    .clk      (clk),
    .rst      (i_rst),
    .p0_req_i (p0_req),
    .p1_req_i (p1_req),
    .take_i   (take),
    .sel_o    (sel)
  );
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    l_d      = l_q;
    u_d      = u_q;
    we_d     = we_q;
    big_d    = big_q;
    wr_d     = wr_q;
    txw_d    = txw_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    rd48_0_d = rd48_0_q;
    rd48_1_d = rd48_1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    take     = state_q == IDLE && m_ready && (p0_req || p1_req);
    tcnt_d   = state_q == IDLE ? '0 : (tcnt_q == TW'(TIMEOUT) ? tcnt_q : tcnt_q + 1'b1);
    to_d     = to_q || tcnt_d == TW'(TIMEOUT);
    case (state_q)
      IDLE: if (take) begin
        state_d = ISSUE;
        cs_d    = 1'b1;
        busy_d  = 1'b1;
        grant_d = sel;
        addr_d  = sel ? p1_addr  : p0_addr;
        we_d    = sel ? p1_we    : p0_we;
        l_d     = sel ? p1_l     : p0_l;
        u_d     = sel ? p1_u     : p0_u;
        wr_d    = sel ? p1_wdata : p0_wdata;
        big_d   = sel ? p1_big   : p0_big;
        txw_d   = sel ? p1_we    : p0_we;
      end
      ISSUE: if (!m_ready) begin
        state_d = WAIT;
        cs_d    = 1'b0;
        l_d     = 1'b0;
        u_d     = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wr_d    = '0;
      end
      WAIT: if (m_ready) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ack0_d  = grant_q == PORT_CPU;
        ack1_d  = grant_q == PORT_CHIP;
        if (!txw_q && grant_q == PORT_CPU)  {rd0_d, rd48_0_d} = {m_RD, m_RD48};
        if (!txw_q && grant_q == PORT_CHIP) {rd1_d, rd48_1_d} = {m_RD, m_RD48};
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      l_q      <= 1'b0;
      u_q      <= 1'b0;
      we_q     <= 1'b0;
      big_q    <= 1'b0;
      wr_q     <= '0;
      txw_q    <= 1'b0;
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      rd48_0_q <= '0;
      rd48_1_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      l_q      <= l_d;
      u_q      <= u_d;
      we_q     <= we_d;
      big_q    <= big_d;
      wr_q     <= wr_d;
      txw_q    <= txw_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      rd48_0_q <= rd48_0_d;
      rd48_1_q <= rd48_1_d;
      tcnt_q   <= tcnt_d;
    end
  end
  assign m_Addr     = addr_q;
  assign m_CS       = cs_q;
  assign m_L        = l_q;
  assign m_U        = u_q;
  assign m_WE       = we_q;
  assign m_WR       = wr_q;
  assign m_big_r    = big_q;
  assign o_grant    = grant_q;
  assign o_busy     = busy_q;
  assign o_timeout  = to_q;
  assign p0_ack     = ack0_q;
  assign p1_ack     = ack1_q;
  assign p0_rdata   = rd0_q;
  assign p1_rdata   = rd1_q;
  assign p0_rdata48 = rd48_0_q;
  assign p1_rdata48 = rd48_1_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scoreboard bench with a reactive sdram_ddr_wrapper ready/data model.
module tb_sdram_port_arbiter;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic i_rst;
  logic p0_req, p1_req, p0_we, p1_we, p0_l, p1_l, p0_u, p1_u, p0_big, p1_big;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [47:0] p0_rdata48, p1_rdata48;
  logic [AW-1:0] m_Addr;
  logic m_CS, m_L, m_U, m_WE, m_big_r;
  logic [15:0] m_WR;
  logic [15:0] m_RD = '0;
  logic [47:0] m_RD48 = '0;
  logic m_ready = 1'b0;
  logic o_grant, o_busy, o_timeout;
  int tests = 0, fails = 0;
  bit cal_hold = 1'b1;
  int low_n = 5;
  logic [15:0] rd_val = '0;
  logic [47:0] rd48_val = '0;
  bit mb = 1'b0;
  int left = 0;
  logic [53:0] iq[$];
  logic [66:0] aq[$];
  logic prev_cs = 1'b0, prev_busy = 1'b0;
  sdram_port_arbiter #(.ADDR_W(AW), .MAX_WAIT(3), .TIMEOUT(1023)) dut (
    .clk(clk), .i_rst(i_rst),
    .p0_req(p0_req), .p1_req(p1_req), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_we(p0_we), .p1_we(p1_we), .p0_l(p0_l), .p1_l(p1_l), .p0_u(p0_u), .p1_u(p1_u),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_big(p0_big), .p1_big(p1_big),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_rdata48(p0_rdata48), .p1_rdata48(p1_rdata48),
    .m_Addr(m_Addr), .m_CS(m_CS), .m_L(m_L), .m_U(m_U), .m_WE(m_WE), .m_WR(m_WR),
    .m_big_r(m_big_r), .m_RD(m_RD), .m_RD48(m_RD48), .m_ready(m_ready),
    .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [53:0] mk_iss(input logic g, we, big, input logic [15:0] wr, input logic [AW-1:0] a);
    return {g, 1'b1, we, 1'b1, 1'b1, big, wr, a};
  endfunction
  function automatic logic [66:0] mk_ack(input logic port, chk, input logic [15:0] rd, input logic [47:0] rd48);
    return {!port, port, chk, rd, rd48};
  endfunction
  // Wrapper model: ready drops the cycle after CS is seen and returns low_n cycles later with read data.
  always @(posedge clk) begin
    #1;
    if (cal_hold) m_ready = 1'b0;
    else if (mb) begin
      left = left - 1;
      if (left == 0) begin
        m_ready = 1'b1;
        m_RD = rd_val;
        m_RD48 = rd48_val;
        mb = 1'b0;
      end
    end else if (m_CS) begin
      mb = 1'b1;
      m_ready = 1'b0;
      left = low_n;
    end else m_ready = 1'b1;
  end
  always @(negedge clk) begin
    logic [66:0] e;
    if (m_CS) begin
      if (iq.size() != 0) check("issue_fields", {o_grant, o_busy, m_WE, m_L, m_U, m_big_r, m_WR, m_Addr}, iq[0]);
      else check("cs_unexpected", m_CS, 1'b0);
      if (!prev_cs) check("cs_overlap", prev_busy, 1'b0);
    end
    if (prev_cs && !m_CS && iq.size() != 0) begin
      void'(iq.pop_front());
      check("accept_clear", {m_Addr, m_WR, m_WE, m_L, m_U}, '0);
    end
    if (p0_ack || p1_ack) begin
      if (aq.size() != 0) begin
        e = aq.pop_front();
        check("ack_port", {p0_ack, p1_ack}, e[66:65]);
        if (e[64]) check("ack_rdata", e[65] ? {p1_rdata, p1_rdata48} : {p0_rdata, p0_rdata48}, e[63:0]);
      end else check("ack_unexpected", p0_ack | p1_ack, 1'b0);
    end
    prev_cs = m_CS;
    prev_busy = o_busy;
  end
  task automatic wait_ack(input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = port ? p1_ack : p0_ack;
    end
    check("ack_arrived", got, 1'b1);
  endtask
  initial begin
    bit seen;
    int n;
    i_rst = 1'b1;
    {p0_req, p1_req, p0_we, p1_we, p0_l, p1_l, p0_u, p1_u, p0_big, p1_big} = '0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {p0_ack, p1_ack, p0_rdata, p1_rdata, p0_rdata48, p1_rdata48, m_Addr, m_CS, m_L,
                            m_U, m_WE, m_WR, m_big_r, o_grant, o_busy, o_timeout}, '0);
    // calibration hold, then p0 write
    p0_addr = 32'h10; p0_wdata = 16'h1234; p0_we = 1'b1; p0_l = 1'b1; p0_u = 1'b1; p0_big = 1'b0;
    p0_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      seen |= m_CS;
    end
    check("cal_no_cs", seen, 1'b0);
    iq.push_back(mk_iss(1'b0, 1'b1, 1'b0, 16'h1234, 32'h10));
    aq.push_back(mk_ack(1'b0, 1'b0, '0, '0));
    cal_hold = 1'b0;
    @(negedge clk);
    check("ready_up_no_cs", {m_ready, m_CS}, 2'b10);
    @(negedge clk);
    check("cs_one_cycle", m_CS, 1'b1);
    wait_ack(1'b0);
    p0_req = 1'b0;
    // p1 big read
    rd_val = 16'hBEEF; rd48_val = 48'h0123_4567_89AB;
    p1_addr = 32'h20; p1_we = 1'b0; p1_l = 1'b1; p1_u = 1'b1; p1_big = 1'b1; p1_wdata = '0;
    iq.push_back(mk_iss(1'b1, 1'b0, 1'b1, 16'h0, 32'h20));
    aq.push_back(mk_ack(1'b1, 1'b1, 16'hBEEF, 48'h0123_4567_89AB));
    p1_req = 1'b1;
    wait_ack(1'b1);
    p1_req = 1'b0;
    rd_val = 16'h0; rd48_val = 48'h0;
    repeat (5) @(negedge clk);
    check("p1_rdata_held", {p1_rdata, p1_rdata48}, {16'hBEEF, 48'h0123_4567_89AB});
    // both ports held: starvation limit forces every 4th grant to port 1
    p0_addr = 32'h100; p0_wdata = 16'hA5A5; p0_we = 1'b1; p0_big = 1'b0;
    p1_addr = 32'h200; p1_we = 1'b0; p1_big = 1'b0;
    rd_val = 16'h5A5A; rd48_val = 48'hCAFE_0000_1111;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) begin
        iq.push_back(mk_iss(1'b1, 1'b0, 1'b0, 16'h0, 32'h200));
        aq.push_back(mk_ack(1'b1, 1'b1, 16'h5A5A, 48'hCAFE_0000_1111));
      end else begin
        iq.push_back(mk_iss(1'b0, 1'b1, 1'b0, 16'hA5A5, 32'h100));
        aq.push_back(mk_ack(1'b0, 1'b0, '0, '0));
      end
    end
    p0_req = 1'b1; p1_req = 1'b1;
    n = 0;
    for (int i = 0; i < 500 && n < 8; i++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) n++;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check("b2b_ack_count", n, 8);
    repeat (3) @(negedge clk);
    // long transaction trips the sticky timeout
    low_n = 1100;
    rd_val = 16'h7777; rd48_val = 48'h1;
    p0_addr = 32'h30; p0_we = 1'b0; p0_wdata = '0;
    iq.push_back(mk_iss(1'b0, 1'b0, 1'b0, 16'h0, 32'h30));
    aq.push_back(mk_ack(1'b0, 1'b1, 16'h7777, 48'h1));
    p0_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_CS;
    end
    check("to_cs_seen", seen, 1'b1);
    repeat (1022) @(negedge clk);
    check("timeout_before", o_timeout, 1'b0);
    @(negedge clk);
    check("timeout_set", o_timeout, 1'b1);
    wait_ack(1'b0);
    p0_req = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_sticky", o_timeout, 1'b1);
    // reset while waiting on the wrapper
    low_n = 20;
    p0_addr = 32'h40; p0_we = 1'b1; p0_wdata = 16'h4444;
    iq.push_back(mk_iss(1'b0, 1'b1, 1'b0, 16'h4444, 32'h40));
    aq.push_back(mk_ack(1'b0, 1'b0, '0, '0));
    p0_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = o_busy && !m_CS;
    end
    check("rst_reached_wait", seen, 1'b1);
    i_rst = 1'b1;
    aq.delete();
    @(negedge clk);
    i_rst = 1'b0;
    check("rst_outputs", {m_CS, o_busy, p0_ack, p1_ack, o_timeout}, 5'b0);
    iq.push_back(mk_iss(1'b0, 1'b1, 1'b0, 16'h4444, 32'h40));
    aq.push_back(mk_ack(1'b0, 1'b0, '0, '0));
    seen = 1'b0;
    for (int i = 0; i < 40 && !m_ready; i++) begin
      seen |= m_CS;
      @(negedge clk);
    end
    check("rst_no_cs_until_ready", {seen, m_ready, m_CS}, 3'b010);
    @(negedge clk);
    check("rst_cs_after_ready", m_CS, 1'b1);
    wait_ack(1'b0);
    p0_req = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", iq.size() + aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
